// File: rtl/render_scheduler.sv
`timescale 1ns/1ps
// render_scheduler: frame sequencer for the ray-tracing renderer.
// On a frame trigger it commits the shadow scene buffer to sphere_out. It then
// streams every active pixel coordinate, in raster order, into the renderer's
// hcount/vcount AXI-stream inputs. A credit counter limits the number of pixels
// in flight. The block reports frame completion and overrun.
//
// Ports:
//   aclk, aresetn                       clock, async active-low reset
//   frame_start_in                      frame request pulse
//   scene_wr_en/addr/data               shadow scene buffer write port
//   sphere_out                          committed scene, stable for the frame
//   hcount_/vcount_axis_tdata/tvalid    pixel coordinate streams (shared valid)
//   hcount_/vcount_axis_tready          renderer ready inputs
//   pixel_done_in                       one pulse per pixel leaving the renderer
//   busy_out, frame_done_out            frame in progress / completion pulse
//   overrun_out                         sticky: dropped trigger or spurious done
module render_scheduler #(
   parameter int unsigned H_ACTIVE     = 1024,
   parameter int unsigned V_ACTIVE     = 768,
   parameter int unsigned MAX_INFLIGHT = 512,
   parameter int unsigned SCENE_WORDS  = 6
) (
   input  logic                      aclk,
   input  logic                      aresetn,
   input  logic                      frame_start_in,
   input  logic                      scene_wr_en,
   input  logic [2:0]                scene_wr_addr,
   input  logic [31:0]               scene_wr_data,
   output logic [32*SCENE_WORDS-1:0] sphere_out,
   output logic [10:0]               hcount_axis_tdata,
   output logic [9:0]                vcount_axis_tdata,
   output logic                      hcount_axis_tvalid,
   output logic                      vcount_axis_tvalid,
   input  logic                      hcount_axis_tready,
   input  logic                      vcount_axis_tready,
   input  logic                      pixel_done_in,
   output logic                      busy_out,
   output logic                      frame_done_out,
   output logic                      overrun_out
);

   localparam int unsigned SPHERE_W = 32 * SCENE_WORDS;
   localparam int unsigned X_W      = 11;
   localparam int unsigned Y_W      = 10;
   localparam int unsigned CRED_W   = $clog2(MAX_INFLIGHT + 1);
   localparam logic [CRED_W-1:0] CRED_MAX = CRED_W'(MAX_INFLIGHT);
   localparam logic [X_W-1:0]    X_LAST   = X_W'(H_ACTIVE - 1);
   localparam logic [Y_W-1:0]    Y_LAST   = Y_W'(V_ACTIVE - 1);

   typedef enum logic [1:0] {IDLE, COMMIT, ISSUE, DRAIN} state_t;

   state_t              state_q, state_nxt;
   logic [X_W-1:0]      x_q, x_nxt;
   logic [Y_W-1:0]      y_q, y_nxt;
   logic [CRED_W-1:0]   credits_q, credits_nxt;
   logic                tvalid_q, tvalid_nxt;
   logic                busy_q, busy_nxt;
   logic                frame_done_q, frame_done_nxt;
   logic                overrun_q, overrun_nxt;
   logic                commit;
   logic [SPHERE_W-1:0] shadow_q;
   logic [SPHERE_W-1:0] sphere_q;

   logic xfer, last_px, credits_full, done_ok, done_spurious;

   // A transfer needs both renderer streams ready; valid never looks at ready.
   assign xfer          = tvalid_q & hcount_axis_tready & vcount_axis_tready;
   assign last_px       = (x_q == X_LAST) && (y_q == Y_LAST);
   assign credits_full  = (credits_q == CRED_MAX);
   assign done_ok       = pixel_done_in & ~credits_full;
   assign done_spurious = pixel_done_in &  credits_full;

   // State register.
   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) state_q <= IDLE;
      else          state_q <= state_nxt;
   end

   // Next-state logic.
   always_comb begin
      state_nxt = state_q;
      unique case (state_q)
         IDLE:   if (frame_start_in) state_nxt = COMMIT;
         COMMIT: state_nxt = ISSUE;
         ISSUE:  if (xfer && last_px) state_nxt = DRAIN;
         DRAIN:  if (credits_full) state_nxt = IDLE;
      endcase
   end

   // Output/datapath next values. They are registered below, so valid, data
   // and status all change on clock edges only.
   always_comb begin
      x_nxt          = x_q;
      y_nxt          = y_q;
      credits_nxt    = credits_q;
      commit         = 1'b0;
      overrun_nxt    = overrun_q;

      unique case ({xfer, done_ok})
         2'b10:   credits_nxt = credits_q - CRED_W'(1);
         2'b01:   credits_nxt = credits_q + CRED_W'(1);
         default: credits_nxt = credits_q;
      endcase

      if (state_q == COMMIT) begin
         commit = 1'b1;
         x_nxt  = '0;
         y_nxt  = '0;
      end else if (xfer) begin
         if (x_q == X_LAST) begin
            x_nxt = '0;
            y_nxt = last_px ? '0 : y_q + Y_W'(1);
         end else begin
            x_nxt = x_q + X_W'(1);
         end
      end

      if ((frame_start_in && (state_q != IDLE)) || done_spurious)
         overrun_nxt = 1'b1;

      // Valid held while credits remain; credits only fall on a transfer, so
      // an offered pixel is never withdrawn.
      tvalid_nxt     = (state_nxt == ISSUE) && (credits_nxt != '0);
      busy_nxt       = (state_nxt != IDLE);
      // Asserted for the single DRAIN cycle that sees all credits home.
      frame_done_nxt = (state_nxt == DRAIN) && (credits_nxt == CRED_MAX);
   end

   // Datapath and status registers.
   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) begin
         x_q          <= '0;
         y_q          <= '0;
         credits_q    <= CRED_MAX;
         tvalid_q     <= 1'b0;
         busy_q       <= 1'b0;
         frame_done_q <= 1'b0;
         overrun_q    <= 1'b0;
         sphere_q     <= '0;
      end else begin
         x_q          <= x_nxt;
         y_q          <= y_nxt;
         credits_q    <= credits_nxt;
         tvalid_q     <= tvalid_nxt;
         busy_q       <= busy_nxt;
         frame_done_q <= frame_done_nxt;
         overrun_q    <= overrun_nxt;
         if (commit) sphere_q <= shadow_q;
      end
   end

   // Shadow scene buffer. A write in the commit cycle lands after the copy.
   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) begin
         shadow_q <= '0;
      end else begin
         for (int unsigned w = 0; w < SCENE_WORDS; w++) begin
            if (scene_wr_en && (32'(scene_wr_addr) == w))
               shadow_q[32*w +: 32] <= scene_wr_data;
         end
      end
   end

   assign sphere_out         = sphere_q;
   assign hcount_axis_tdata  = x_q;
   assign vcount_axis_tdata  = y_q;
   assign hcount_axis_tvalid = tvalid_q;
   assign vcount_axis_tvalid = tvalid_q;
   assign busy_out           = busy_q;
   assign frame_done_out     = frame_done_q;
   assign overrun_out        = overrun_q;

endmodule
